// File: rtl/demux2_reg.sv
// rtl/demux2_reg.sv - registered 1-to-2 demux with per-output holding registers
// A stalled sink only back-pressures words addressed to it; the other path keeps flowing.
module demux2_reg #(
    parameter int N  = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [N-1:0]  out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [N-1:0]  out1_data,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic          busy
);

    logic          out0_valid_q, out0_valid_d;
    logic          out1_valid_q, out1_valid_d;
    logic [N-1:0]  out0_data_q, out0_data_d;
    logic [N-1:0]  out1_data_q, out1_data_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic room0, room1;
    logic load0, load1;
    logic drain0, drain1;

    // in_ready never looks at in_valid, so upstream may derive valid from ready.
    assign room0    = !out0_valid_q || out0_ready;
    assign room1    = !out1_valid_q || out1_ready;
    assign in_ready = reset && (in_sel ? room1 : room0);

    assign load0  = in_valid && in_ready && !in_sel;
    assign load1  = in_valid && in_ready && in_sel;
    assign drain0 = out0_valid_q && out0_ready;
    assign drain1 = out1_valid_q && out1_ready;

    always_comb begin
        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (load0) begin
            out0_valid_d = 1'b1;
            out0_data_d  = in_data;
        end else if (drain0) begin
            out0_valid_d = 1'b0;
        end

        if (load1) begin
            out1_valid_d = 1'b1;
            out1_data_d  = in_data;
        end else if (drain1) begin
            out1_valid_d = 1'b0;
        end

        if (drain0) cnt0_d = cnt0_q + 1'b1;
        if (drain1) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out0_valid = out0_valid_q;
    assign out1_valid = out1_valid_q;
    assign out0_data  = out0_data_q;
    assign out1_data  = out1_data_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;
    assign busy       = out0_valid_q || out1_valid_q;

endmodule
